// File: rtl/stream_qos_pkg.sv
// -----------------------------------------------------------------------------
// stream_qos_pkg
// Shared types and constants for the QoS stream demultiplexer.
//   demux_state_e : packet routing FSM states (IDLE, BUSY, DROP)
//   DROP_CNT_W    : width of the dropped-packet counter
//   sat_inc       : saturating increment for the dropped-packet counter
// -----------------------------------------------------------------------------
package stream_qos_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for the first beat of a packet
        BUSY = 2'd1,   // mid-packet, route locked
        DROP = 2'd2    // mid-packet with an illegal id, beats discarded
    } demux_state_e;

    localparam int DROP_CNT_W = 16;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/stream_demux_hold_reg.sv
// -----------------------------------------------------------------------------
// stream_demux_hold_reg
// One-entry valid/ready register slice carrying a beat plus its route select.
// Supports full throughput: the held beat can be consumed and a new one loaded
// on the same edge.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid_i/in_ready_o   upstream handshake
//   in_data_i/qos_i/last_i  beat payload
//   in_sel_i                destination stream index for this beat
//   out_valid_o/out_ready_i downstream handshake (ready of the selected stream)
//   out_data_o/qos_o/last_o/sel_o  held beat
// -----------------------------------------------------------------------------
module stream_demux_hold_reg #(
    parameter int DW = 4,
    parameter int QW = 2,
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    input  logic [QW-1:0] in_qos_i,
    input  logic          in_last_i,
    input  logic [IW-1:0] in_sel_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [QW-1:0] out_qos_o,
    output logic          out_last_o,
    output logic [IW-1:0] out_sel_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;
    logic [QW-1:0] qos_q;
    logic          last_q;
    logic [IW-1:0] sel_q;

    // Free when empty or when the held beat leaves on this edge.
    assign in_ready_o = !valid_q || out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            qos_q   <= '0;
            last_q  <= 1'b0;
            sel_q   <= '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
            qos_q   <= in_qos_i;
            last_q  <= in_last_i;
            sel_q   <= in_sel_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_qos_o   = qos_q;
    assign out_last_o  = last_q;
    assign out_sel_o   = sel_q;

endmodule

// File: rtl/stream_demux_w_qos.sv
// -----------------------------------------------------------------------------
// stream_demux_w_qos
// Splits one merged, id/qos-tagged stream back into STREAM_COUNT streams.
// The route is taken from s_id_in on a packet's first beat and held until its
// last beat. One register stage (stream_demux_hold_reg) sits on the output;
// qos passes through untouched.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   s_data/qos/id/last/valid_in      merged input stream
//   s_ready_out                      merged input ready
//   m_data/qos/last/valid_out        per-stream outputs (at most one valid)
//   m_ready_in                       per-stream ready
//   m_drop_cnt_out                   dropped-packet count (ILLEGAL_ID_DROP_EN only)
// Configuration macro ILLEGAL_ID_DROP_EN:
//   defined   - packets whose first-beat id >= STREAM_COUNT are consumed and
//               discarded, and counted (saturating) on m_drop_cnt_out.
//   undefined - such ids route to stream STREAM_COUNT-1.
// -----------------------------------------------------------------------------
module stream_demux_w_qos
    import stream_qos_pkg::*;
#(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_QOS__WIDTH = 2,
    parameter int STREAM_COUNT = 2,
    parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [T_DATA_WIDTH-1:0]                     s_data_in,
    input  logic [T_QOS__WIDTH-1:0]                     s_qos_in,
    input  logic [T_ID___WIDTH-1:0]                     s_id_in,
    input  logic                                        s_last_in,
    input  logic                                        s_valid_in,
    output logic                                        s_ready_out,
    output logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0]   m_data_out,
    output logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0]   m_qos_out,
    output logic [STREAM_COUNT-1:0]                     m_last_out,
    output logic [STREAM_COUNT-1:0]                     m_valid_out,
    input  logic [STREAM_COUNT-1:0]                     m_ready_in
`ifdef ILLEGAL_ID_DROP_EN
    ,
    output logic [DROP_CNT_W-1:0]                       m_drop_cnt_out
`endif
);

    demux_state_e            state_q, state_d;
    logic [T_ID___WIDTH-1:0] sel_lock_q, sel_lock_d;

    logic                    id_illegal;
    logic [T_ID___WIDTH-1:0] first_sel;
    logic [T_ID___WIDTH-1:0] route_sel;
    logic                    drop_beat;
    logic                    accept;
    logic                    hold_in_valid;
    logic                    hold_in_ready;
    logic                    hold_valid;
    logic                    hold_out_ready;
    logic [T_DATA_WIDTH-1:0] hold_data;
    logic [T_QOS__WIDTH-1:0] hold_qos;
    logic                    hold_last;
    logic [T_ID___WIDTH-1:0] hold_sel;
    logic [STREAM_COUNT-1:0] sel_hit;

    // Only reachable when STREAM_COUNT is not a power of two.
    assign id_illegal = (32'(s_id_in) >= 32'(STREAM_COUNT));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_lock_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_lock_q <= sel_lock_d;
        end
    end

    // ---------------- FSM: next-state ----------------
    always_comb begin
        state_d    = state_q;
        sel_lock_d = sel_lock_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (drop_beat) begin
                        state_d = s_last_in ? IDLE : DROP;
                    end else begin
                        sel_lock_d = route_sel;
                        state_d    = s_last_in ? IDLE : BUSY;
                    end
                end
            end
            BUSY: begin
                if (accept && s_last_in) state_d = IDLE;
            end
            DROP: begin
                if (accept && s_last_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (route, handshake) ----------------
    always_comb begin
        first_sel = s_id_in;
        drop_beat = 1'b0;
`ifdef ILLEGAL_ID_DROP_EN
        drop_beat = (state_q == DROP) || ((state_q == IDLE) && id_illegal);
`else
        if (id_illegal) first_sel = T_ID___WIDTH'(STREAM_COUNT - 1);
`endif
        // Mid-packet beats ignore s_id_in and follow the locked route.
        route_sel     = (state_q == BUSY) ? sel_lock_q : first_sel;
        // Dropped beats bypass the hold register, so they never wait on it.
        s_ready_out   = rst_n && (drop_beat || hold_in_ready);
        accept        = s_valid_in && s_ready_out;
        hold_in_valid = s_valid_in && rst_n && !drop_beat;
    end

    stream_demux_hold_reg #(
        .DW (T_DATA_WIDTH),
        .QW (T_QOS__WIDTH),
        .IW (T_ID___WIDTH)
    ) u_hold (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (hold_in_valid),
        .in_ready_o  (hold_in_ready),
        .in_data_i   (s_data_in),
        .in_qos_i    (s_qos_in),
        .in_last_i   (s_last_in),
        .in_sel_i    (route_sel),
        .out_valid_o (hold_valid),
        .out_ready_i (hold_out_ready),
        .out_data_o  (hold_data),
        .out_qos_o   (hold_qos),
        .out_last_o  (hold_last),
        .out_sel_o   (hold_sel)
    );

    // One-hot decode of the held beat onto its stream; others are forced to 0.
    for (genvar gi = 0; gi < STREAM_COUNT; gi++) begin : g_out
        assign sel_hit[gi]     = (hold_sel == T_ID___WIDTH'(gi));
        assign m_valid_out[gi] = hold_valid && sel_hit[gi];
        assign m_data_out[gi]  = m_valid_out[gi] ? hold_data : '0;
        assign m_qos_out[gi]   = m_valid_out[gi] ? hold_qos  : '0;
        assign m_last_out[gi]  = m_valid_out[gi] && hold_last;
    end

    // Only the selected stream's ready can release the held beat.
    assign hold_out_ready = |(m_ready_in & sel_hit);

`ifdef ILLEGAL_ID_DROP_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    // Count on the first beat of a dropped packet so each packet counts once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (accept && drop_beat && (state_q == IDLE)) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
        end
    end

    assign m_drop_cnt_out = drop_cnt_q;
`endif

endmodule
